// File: rtl/exp_shift_cfg_seq.sv
// exp_shift_cfg_seq: runtime configuration sequencer for the exponent shifter.
// A config write is accepted only in RUN. It is held pending until the next
// frame boundary of the monitored stream and then applied. After that the
// block reports settle while the exponent average refills over avg_len frames.
// Optional macro EXP_SHIFT_CFG_STATS_EN: when defined, frame_cnt counts frame
// starts; when undefined, frame_cnt is tied to zero.
module exp_shift_cfg_seq #(
    parameter logic [9:0] DEF_FFT_SIZE = 10'd512,
    parameter logic [8:0] DEF_AVG_LEN  = 9'd256
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        cfg_valid,
    input  logic [9:0]  cfg_fft_size,
    input  logic [8:0]  cfg_avg_len,
    output logic        cfg_ready,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic [23:0] mon_tuser,
    output logic [9:0]  fft_size,
    output logic [8:0]  avg_len,
    output logic        avg_restart,
    output logic        settle,
    output logic        cfg_err,
    output logic [31:0] frame_cnt
);

    typedef enum logic [1:0] {RUN, PEND, SETTLE} state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] pend_fft_size;
    logic [8:0] pend_avg_len;
    logic [8:0] settle_cnt;
    logic [8:0] settle_cnt_inc;
    logic       frame_start;
    logic       accept;
    logic       fft_ok;
    logic       avg_ok;
    logic       cfg_ok;
    logic       unused_tuser;

    // Only the FFT bin field of tuser identifies a frame boundary.
    assign unused_tuser   = ^mon_tuser[23:9];
    assign frame_start    = mon_tvalid && mon_tready && (mon_tuser[8:0] == 9'd0);
    assign accept         = cfg_valid && cfg_ready;
    assign settle_cnt_inc = settle_cnt + 9'd1;

    // A legal FFT size is a single set bit between 8 and 512.
    assign fft_ok = ((cfg_fft_size & (cfg_fft_size - 10'd1)) == 10'd0)
                    && (cfg_fft_size >= 10'd8) && (cfg_fft_size <= 10'd512);
    assign avg_ok = (cfg_avg_len != 9'd0) && (cfg_avg_len <= 9'd256);
    assign cfg_ok = fft_ok && avg_ok;

    assign cfg_ready = (state == RUN);
    assign settle    = (state == SETTLE);

    // State register; reset returns to RUN.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) state <= RUN;
        else            state <= state_next;
    end

    // Next-state logic: RUN waits for a legal write, PEND for a frame start,
    // SETTLE for avg_len further frame starts.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && cfg_ok) state_next = PEND;
            PEND:    if (frame_start) state_next = SETTLE;
            SETTLE:  if (frame_start && (settle_cnt_inc == avg_len)) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Config datapath: error flag, pending latch, applied values and settle count.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            fft_size      <= DEF_FFT_SIZE;
            avg_len       <= DEF_AVG_LEN;
            avg_restart   <= 1'b0;
            cfg_err       <= 1'b0;
            pend_fft_size <= 10'd0;
            pend_avg_len  <= 9'd0;
            settle_cnt    <= 9'd0;
        end else begin
            avg_restart <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (cfg_ok) begin
                            cfg_err       <= 1'b0;
                            pend_fft_size <= cfg_fft_size;
                            pend_avg_len  <= cfg_avg_len;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (frame_start) begin
                        fft_size    <= pend_fft_size;
                        avg_len     <= pend_avg_len;
                        avg_restart <= 1'b1;
                        settle_cnt  <= 9'd0;
                    end
                end
                SETTLE: begin
                    if (frame_start) settle_cnt <= settle_cnt_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef EXP_SHIFT_CFG_STATS_EN
    logic [31:0] frame_cnt_q;

    // Free-running frame-start counter, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset)       frame_cnt_q <= 32'd0;
        else if (frame_start) frame_cnt_q <= frame_cnt_q + 32'd1;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_exp_shift_cfg_seq.sv
// tb_exp_shift_cfg_seq: self-checking bench for exp_shift_cfg_seq.
// Expected applied configs are queued when a write is issued that should
// apply. They are popped and compared whenever the DUT pulses avg_restart.
module tb_exp_shift_cfg_seq;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [9:0]  cfg_fft_size = 10'd0;
    logic [8:0]  cfg_avg_len = 9'd0;
    logic        cfg_ready;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic [23:0] mon_tuser = 24'd0;
    logic [9:0]  fft_size;
    logic [8:0]  avg_len;
    logic        avg_restart;
    logic        settle;
    logic        cfg_err;
    logic [31:0] frame_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [18:0] sb_q[$];

    exp_shift_cfg_seq dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .cfg_valid    (cfg_valid),
        .cfg_fft_size (cfg_fft_size),
        .cfg_avg_len  (cfg_avg_len),
        .cfg_ready    (cfg_ready),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tuser    (mon_tuser),
        .fft_size     (fft_size),
        .avg_len      (avg_len),
        .avg_restart  (avg_restart),
        .settle       (settle),
        .cfg_err      (cfg_err),
        .frame_cnt    (frame_cnt)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Scoreboard: every restart pulse must match the oldest queued config.
    always @(negedge clk) begin
        if (avg_restart === 1'b1) begin
            logic [18:0] exp_cfg;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_restart: got fft=%0d avg=%0d, expected no restart", fft_size, avg_len);
            end else begin
                exp_cfg = sb_q.pop_front();
                if ({fft_size, avg_len} !== exp_cfg) begin
                    errors++;
                    $display("[TB] FAIL sb_applied: got fft=%0d avg=%0d, expected fft=%0d avg=%0d",
                             fft_size, avg_len, exp_cfg[18:9], exp_cfg[8:0]);
                end
            end
        end
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [9:0] f, input logic [8:0] a);
        cfg_valid    = 1'b1;
        cfg_fft_size = f;
        cfg_avg_len  = a;
        tick();
        cfg_valid    = 1'b0;
    endtask

    task automatic frame();
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = 24'd0;
        tick();
        mon_tvalid = 1'b0;
        mon_tuser  = 24'h000107;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        tick();
        tick();
        sync_reset = 1'b0;
        tick();
        checks++; if (fft_size !== 10'd512) begin errors++; $display("[TB] FAIL reset_fft: got %0d expected 512", fft_size); end
        checks++; if (avg_len !== 9'd256) begin errors++; $display("[TB] FAIL reset_avg: got %0d expected 256", avg_len); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready); end
        checks++; if (settle !== 1'b0) begin errors++; $display("[TB] FAIL reset_settle: got %b expected 0", settle); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", cfg_err); end
        checks++; if (avg_restart !== 1'b0) begin errors++; $display("[TB] FAIL reset_restart: got %b expected 0", avg_restart); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    endtask

    task automatic test_normal_apply();
        write_cfg(10'd64, 9'd4);
        sb_q.push_back({10'd64, 9'd4});
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ready: got %b expected 0", cfg_ready); end
        // Nine cycles of non-frame traffic: stalled bin 0, busy bins, idle.
        for (int i = 0; i < 9; i++) begin
            mon_tvalid = (i % 3 != 2);
            mon_tready = (i % 3 != 0);
            mon_tuser  = (i % 3 == 1) ? 24'h000105 : 24'h000000;
            tick();
        end
        mon_tvalid = 1'b0;
        checks++; if ({fft_size, avg_len} !== {10'd512, 9'd256}) begin errors++; $display("[TB] FAIL pend_hold: got fft=%0d avg=%0d expected 512/256", fft_size, avg_len); end
        frame();
        checks++; if ({fft_size, avg_len} !== {10'd64, 9'd4}) begin errors++; $display("[TB] FAIL apply_vals: got fft=%0d avg=%0d expected 64/4", fft_size, avg_len); end
        checks++; if (avg_restart !== 1'b1) begin errors++; $display("[TB] FAIL apply_restart: got %b expected 1", avg_restart); end
        checks++; if (settle !== 1'b1) begin errors++; $display("[TB] FAIL apply_settle: got %b expected 1", settle); end
        tick();
        checks++; if (avg_restart !== 1'b0) begin errors++; $display("[TB] FAIL restart_width: got %b expected 0", avg_restart); end
        for (int i = 1; i <= 4; i++) begin
            frame();
            checks++;
            if (settle !== (i < 4)) begin errors++; $display("[TB] FAIL settle_frame%0d: got %b expected %b", i, settle, (i < 4)); end
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL settle_done_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_reject();
        write_cfg(10'd100, 9'd4);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL reject_fft_err: got %b expected 1", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reject_ready: got %b expected 1", cfg_ready); end
        write_cfg(10'd64, 9'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL reject_avg0_err: got %b expected 1", cfg_err); end
        write_cfg(10'd4, 9'd4);
        write_cfg(10'd64, 9'd257);
        checks++; if ({fft_size, avg_len} !== {10'd64, 9'd4}) begin errors++; $display("[TB] FAIL reject_hold: got fft=%0d avg=%0d expected 64/4", fft_size, avg_len); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reject_ready2: got %b expected 1", cfg_ready); end
        frame();
        write_cfg(10'd128, 9'd2);
        sb_q.push_back({10'd128, 9'd2});
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reject_clear: got %b expected 0", cfg_err); end
        frame();
        frame();
        checks++; if (settle !== 1'b1) begin errors++; $display("[TB] FAIL avg2_settle1: got %b expected 1", settle); end
        frame();
        checks++; if (settle !== 1'b0) begin errors++; $display("[TB] FAIL avg2_settle2: got %b expected 0", settle); end
    endtask

    task automatic test_boundary();
        write_cfg(10'd8, 9'd1);
        sb_q.push_back({10'd8, 9'd1});
        frame();
        checks++; if ({fft_size, avg_len} !== {10'd8, 9'd1}) begin errors++; $display("[TB] FAIL min_vals: got fft=%0d avg=%0d expected 8/1", fft_size, avg_len); end
        tick();
        checks++; if (settle !== 1'b1) begin errors++; $display("[TB] FAIL avg1_settle_hold: got %b expected 1", settle); end
        frame();
        checks++; if (settle !== 1'b0) begin errors++; $display("[TB] FAIL avg1_settle_end: got %b expected 0", settle); end
    endtask

    task automatic test_back_to_back();
        // Write coincident with a frame start must wait for the next one.
        cfg_valid = 1'b1; cfg_fft_size = 10'd32; cfg_avg_len = 9'd8;
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = 24'd0;
        tick();
        cfg_valid = 1'b0; mon_tvalid = 1'b0; mon_tuser = 24'h000107;
        checks++; if (avg_restart !== 1'b0) begin errors++; $display("[TB] FAIL coincident_restart: got %b expected 0", avg_restart); end
        checks++; if (fft_size !== 10'd8) begin errors++; $display("[TB] FAIL coincident_hold: got %0d expected 8", fft_size); end
        tick();
        sb_q.push_back({10'd32, 9'd8});
        frame();
        checks++; if ({fft_size, avg_len} !== {10'd32, 9'd8}) begin errors++; $display("[TB] FAIL next_frame_apply: got fft=%0d avg=%0d expected 32/8", fft_size, avg_len); end
        cfg_valid = 1'b1; cfg_fft_size = 10'd256; cfg_avg_len = 9'd16;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL settle_ready: got %b expected 0", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 8; i++) frame();
        checks++; if (settle !== 1'b0) begin errors++; $display("[TB] FAIL avg8_settle_end: got %b expected 0", settle); end
        frame();
        checks++; if ({fft_size, avg_len} !== {10'd32, 9'd8}) begin errors++; $display("[TB] FAIL settle_write_dropped: got fft=%0d avg=%0d expected 32/8", fft_size, avg_len); end
    endtask

    task automatic test_reset_mid();
        write_cfg(10'd16, 9'd2);
        #2;
        sync_reset = 1'b1;
        #1;
        checks++; if ({fft_size, avg_len} !== {10'd512, 9'd256}) begin errors++; $display("[TB] FAIL async_reset: got fft=%0d avg=%0d expected 512/256", fft_size, avg_len); end
        frame();
        sync_reset = 1'b0;
        tick();
        frame();
        frame();
        checks++; if ({fft_size, avg_len} !== {10'd512, 9'd256}) begin errors++; $display("[TB] FAIL reset_pend_discard: got fft=%0d avg=%0d expected 512/256", fft_size, avg_len); end
        checks++; if ({cfg_ready, settle} !== 2'b10) begin errors++; $display("[TB] FAIL reset_pend_state: got ready/settle=%b expected 10", {cfg_ready, settle}); end
    endtask

    task automatic test_stats();
`ifdef EXP_SHIFT_CFG_STATS_EN
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        for (int i = 0; i < 3; i++) frame();
        checks++; if (frame_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stats_count: got %0d expected 3", frame_cnt); end
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.frame_cnt_q;
        frame();
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stats_wrap: got %0d expected 0", frame_cnt); end
`else
        for (int i = 0; i < 3; i++) frame();
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stats_tied: got %0d expected 0", frame_cnt); end
`endif
    endtask

    // Scenario sequence followed by the final scoreboard drain check.
    initial begin
        test_reset();
        test_normal_apply();
        test_reject();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending applies expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
